// File: rtl/addn_serial.sv
// Serial multi-operand adder: sums up to NOPS operands (optionally inverted) plus a frame carry-in.
// Optional feature macro: ADDN_SERIAL_EARLY_LAST_EN (honour in_last to end a frame early).
module addn_serial #(
  parameter  int WIDTH = 8,
  parameter  int NOPS  = 3,
  localparam int ACC_W = WIDTH + $clog2(NOPS) + 1,
  localparam int CNT_W = $clog2(NOPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op,
  input  logic             in_inv,
  input  logic             in_cin,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_nops,
  output logic [1:0]       dbg_state
);

  // Handshake: a beat moves on a rising edge with in_valid && in_ready, a result
  // with out_valid && out_ready; ready/valid are decoded from state only.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_beat;
  logic             w_last;
  logic [ACC_W-1:0] w_opx;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_beat     = in_valid && in_ready;
  assign w_opx      = {{(ACC_W-WIDTH){1'b0}}, (in_inv ? ~in_op : in_op)};
  assign w_cnt_next = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);

`ifdef ADDN_SERIAL_EARLY_LAST_EN
  assign w_last = (w_cnt_next == CNT_W'(NOPS)) || in_last;
`else
  logic w_unused_last;
  assign w_unused_last = in_last;
  assign w_last        = (w_cnt_next == CNT_W'(NOPS));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_beat) w_next_state = w_last ? S_DONE : S_ACC;
      S_ACC:  if (w_beat) w_next_state = w_last ? S_DONE : S_ACC;
      S_DONE: if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state != S_DONE);
    out_valid = (r_state == S_DONE);
    dbg_state = r_state;
  end

  // Carry-in only enters on the first beat; it fits in the spare top bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_beat) begin
      r_acc <= (r_state == S_IDLE) ? (w_opx + ACC_W'(in_cin)) : (r_acc + w_opx);
      r_cnt <= w_cnt_next;
    end
  end

  assign out_sum  = r_acc;
  assign out_nops = r_cnt;

endmodule

// File: tb/tb_addn_serial.sv
// Self-checking bench for addn_serial (WIDTH=8, NOPS=3) against an arithmetic frame model.
module tb_addn_serial;
  localparam int WIDTH = 8;
  localparam int NOPS  = 3;
  localparam int ACC_W = 11;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_op;
  logic             in_inv;
  logic             in_cin;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_nops;
  logic [1:0]       dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  logic [WIDTH-1:0] f_op   [NOPS];
  bit               f_inv  [NOPS];
  bit               f_cin  [NOPS];
  bit               f_last [NOPS];

  addn_serial #(.WIDTH(WIDTH), .NOPS(NOPS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_inv(in_inv), .in_cin(in_cin), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_nops(out_nops), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int frame_len();
`ifdef ADDN_SERIAL_EARLY_LAST_EN
    for (int i = 0; i < NOPS; i++) if (f_last[i]) return i + 1;
`endif
    return NOPS;
  endfunction

  function automatic int unsigned ref_sum();
    int unsigned s;
    s = f_cin[0] ? 1 : 0;
    for (int i = 0; i < frame_len(); i++)
      s += f_inv[i] ? (255 - int'(f_op[i])) : int'(f_op[i]);
    return s;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_frame();
    for (int i = 0; i < NOPS; i++) begin
      f_op[i] = '0; f_inv[i] = 0; f_cin[i] = 0; f_last[i] = 0;
    end
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] op, input bit inv, input bit cin,
                           input bit last, output bit ok);
    int budget;
    budget = 0;
    in_valid = 1'b1; in_op = op; in_inv = inv; in_cin = cin; in_last = last;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    ok = in_ready;
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drive_frame(input int max_gap, output bit ok);
    bit b_ok;
    ok = 1;
    for (int i = 0; i < frame_len(); i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_beat(f_op[i], f_inv[i], f_cin[i], f_last[i], b_ok);
      ok &= b_ok;
    end
  endtask

  task automatic wait_result(output bit ok);
    int budget;
    budget = 0;
    while (!out_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    ok = out_valid;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_op = '0; in_inv = 0; in_cin = 0; in_last = 0; out_ready = 0;
    #23;
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got=%b exp=1", in_ready); n_miss++; end
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%b exp=0", out_valid); n_miss++; end
    n_vec++; if (out_sum !== 11'h000) begin $display("FAIL reset_out_sum got=%h exp=000", out_sum); n_miss++; end
    n_vec++; if (out_nops !== 2'd0) begin $display("FAIL reset_out_nops got=%0d exp=0", out_nops); n_miss++; end
    n_vec++; if (dbg_state !== 2'd0) begin $display("FAIL reset_state got=%0d exp=0", dbg_state); n_miss++; end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    clear_frame();
    f_op = '{8'h10, 8'h20, 8'h30};
    drive_frame(0, ok);
    n_vec++; if (!ok) begin $display("FAIL basic_accept got=timeout exp=accepted"); n_miss++; end
    n_vec++; if (out_valid !== 1'b1) begin $display("FAIL basic_latency out_valid got=%b exp=1", out_valid); n_miss++; end
    n_vec++; if (in_ready !== 1'b0) begin $display("FAIL basic_done_ready got=%b exp=0", in_ready); n_miss++; end
    n_vec++; if (out_sum !== 11'h060) begin $display("FAIL basic_sum got=%h exp=060", out_sum); n_miss++; end
    n_vec++; if (out_nops !== 2'd3) begin $display("FAIL basic_nops got=%0d exp=3", out_nops); n_miss++; end
    take_result();
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL basic_ready_after_take got=%b exp=1", in_ready); n_miss++; end
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL basic_valid_after_take got=%b exp=0", out_valid); n_miss++; end
  endtask

  task automatic test_max_and_cin();
    bit ok;
    clear_frame();
    f_op = '{8'hFF, 8'hFF, 8'hFF};
    f_cin[0] = 1;
    drive_frame(0, ok);
    wait_result(ok);
    n_vec++; if (!ok) begin $display("FAIL max_timeout got=no_result exp=result"); n_miss++; end
    n_vec++; if (out_sum !== 11'h2FE) begin $display("FAIL max_sum got=%h exp=2fe", out_sum); n_miss++; end
    take_result();
    f_cin = '{0, 1, 1};
    drive_frame(0, ok);
    wait_result(ok);
    n_vec++; if (!ok) begin $display("FAIL cin_ignored_timeout got=no_result exp=result"); n_miss++; end
    n_vec++; if (out_sum !== 11'h2FD) begin $display("FAIL cin_ignored_sum got=%h exp=2fd", out_sum); n_miss++; end
    take_result();
  endtask

  task automatic test_inversion();
    bit ok;
    clear_frame();
    f_op  = '{8'h0F, 8'h01, 8'h00};
    f_inv = '{1, 0, 1};
    drive_frame(1, ok);
    wait_result(ok);
    n_vec++; if (!ok) begin $display("FAIL inv_timeout got=no_result exp=result"); n_miss++; end
    n_vec++; if (out_sum !== 11'h1F0) begin $display("FAIL inv_sum got=%h exp=1f0", out_sum); n_miss++; end
    take_result();
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_frame();
    f_op = '{8'h01, 8'h02, 8'h03};
    drive_frame(0, ok);
    wait_result(ok);
    n_vec++; if (!ok) begin $display("FAIL bp_timeout got=no_result exp=result"); n_miss++; end
    in_valid = 1'b1; in_op = 8'hAA; in_inv = 0; in_cin = 1; in_last = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1) begin $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, out_valid); n_miss++; end
      n_vec++; if (in_ready !== 1'b0) begin $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, in_ready); n_miss++; end
      n_vec++; if (out_sum !== 11'h006) begin $display("FAIL bp_sum cyc=%0d got=%h exp=006", c, out_sum); n_miss++; end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL bp_release_ready got=%b exp=1", in_ready); n_miss++; end
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL bp_release_valid got=%b exp=0", out_valid); n_miss++; end
    f_op = '{8'h11, 8'h22, 8'h33};
    drive_frame(0, ok);
    wait_result(ok);
    n_vec++; if (!ok) begin $display("FAIL bp_next_timeout got=no_result exp=result"); n_miss++; end
    n_vec++; if (out_sum !== 11'h066) begin $display("FAIL bp_next_sum got=%h exp=066", out_sum); n_miss++; end
    n_vec++; if (out_nops !== 2'd3) begin $display("FAIL bp_next_nops got=%0d exp=3", out_nops); n_miss++; end
    take_result();
  endtask

  task automatic test_early_last();
    bit ok, ok2;
    bit exp_valid;
`ifdef ADDN_SERIAL_EARLY_LAST_EN
    exp_valid = 1;
`else
    exp_valid = 0;
`endif
    send_beat(8'h05, 0, 0, 0, ok);
    send_beat(8'h07, 0, 0, 1, ok2);
    n_vec++; if (!(ok && ok2)) begin $display("FAIL early_accept got=timeout exp=accepted"); n_miss++; end
    n_vec++; if (out_valid !== exp_valid) begin $display("FAIL early_valid got=%b exp=%b", out_valid, exp_valid); n_miss++; end
`ifdef ADDN_SERIAL_EARLY_LAST_EN
    n_vec++; if (out_sum !== 11'h00C) begin $display("FAIL early_sum got=%h exp=00c", out_sum); n_miss++; end
    n_vec++; if (out_nops !== 2'd2) begin $display("FAIL early_nops got=%0d exp=2", out_nops); n_miss++; end
`else
    send_beat(8'h01, 0, 0, 0, ok);
    wait_result(ok2);
    n_vec++; if (!(ok && ok2)) begin $display("FAIL early_third got=timeout exp=result"); n_miss++; end
    n_vec++; if (out_sum !== 11'h00D) begin $display("FAIL early_sum got=%h exp=00d", out_sum); n_miss++; end
    n_vec++; if (out_nops !== 2'd3) begin $display("FAIL early_nops got=%0d exp=3", out_nops); n_miss++; end
`endif
    take_result();
  endtask

  task automatic test_reset_mid_frame();
    bit ok, ok2;
    send_beat(8'h40, 0, 1, 0, ok);
    send_beat(8'h40, 0, 0, 0, ok2);
    n_vec++; if (!(ok && ok2)) begin $display("FAIL midrst_accept got=timeout exp=accepted"); n_miss++; end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (dbg_state !== 2'd0) begin $display("FAIL midrst_state got=%0d exp=0", dbg_state); n_miss++; end
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL midrst_valid got=%b exp=0", out_valid); n_miss++; end
    n_vec++; if (out_sum !== 11'h000) begin $display("FAIL midrst_sum got=%h exp=000", out_sum); n_miss++; end
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL midrst_ready got=%b exp=1", in_ready); n_miss++; end
    @(negedge clk);
    rst_n = 1'b1;
    clear_frame();
    f_op = '{8'h01, 8'h01, 8'h01};
    drive_frame(0, ok);
    wait_result(ok2);
    n_vec++; if (!(ok && ok2)) begin $display("FAIL midrst_frame got=timeout exp=result"); n_miss++; end
    n_vec++; if (out_sum !== 11'h003) begin $display("FAIL midrst_frame_sum got=%h exp=003", out_sum); n_miss++; end
    n_vec++; if (out_nops !== 2'd3) begin $display("FAIL midrst_frame_nops got=%0d exp=3", out_nops); n_miss++; end
    take_result();
  endtask

  task automatic test_random();
    bit ok, ok2;
    int unsigned exp_sum;
    int exp_n;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NOPS; i++) begin
        f_op[i]   = 8'($urandom_range(0, 255));
        f_inv[i]  = 1'($urandom_range(0, 1));
        f_cin[i]  = 1'($urandom_range(0, 1));
        f_last[i] = ($urandom_range(0, 3) == 0);
      end
      exp_sum = ref_sum();
      exp_n   = frame_len();
      drive_frame(2, ok);
      wait_result(ok2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_vec++; if (!(ok && ok2)) begin $display("FAIL rand_timeout frame=%0d got=timeout exp=result", f); n_miss++; end
      n_vec++; if (out_sum !== ACC_W'(exp_sum)) begin $display("FAIL rand_sum frame=%0d got=%h exp=%h", f, out_sum, ACC_W'(exp_sum)); n_miss++; end
      n_vec++; if (out_nops !== CNT_W'(exp_n)) begin $display("FAIL rand_nops frame=%0d got=%0d exp=%0d", f, out_nops, exp_n); n_miss++; end
      take_result();
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ok2;
    clear_frame();
    for (int f = 0; f < 4; f++) begin
      f_op = '{8'(f * 3 + 1), 8'(f * 5 + 2), 8'(f * 7 + 3)};
      drive_frame(0, ok);
      n_vec++; if (!ok || out_valid !== 1'b1) begin $display("FAIL b2b_valid frame=%0d got=%b exp=1", f, out_valid); n_miss++; end
      n_vec++; if (out_sum !== ACC_W'(ref_sum())) begin $display("FAIL b2b_sum frame=%0d got=%h exp=%h", f, out_sum, ACC_W'(ref_sum())); n_miss++; end
      take_result();
      ok2 = in_ready;
      n_vec++; if (ok2 !== 1'b1) begin $display("FAIL b2b_ready frame=%0d got=%b exp=1", f, ok2); n_miss++; end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    clear_frame();
    test_reset();
    test_basic();
    test_max_and_cin();
    test_inversion();
    test_backpressure();
    test_early_last();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
